fastram_cycle_ctrl: RTL

// - Clocked SRAM cycle sequencer directly downstream of the RAM autoconfig decoder; consumes its ramce (base-address match) and runs the Fast RAM access.
// - Synchronises the asynchronous 68000 strobes, latches the word address, and drives SRAM chip/byte-lane/OE/WE controls plus the CPU data buffer enable.
// - Times the access with a programmable wait-state counter and returns a registered DTACK (positive logic) until the CPU ends the bus cycle.

---
 rtl/fastram_cycle_ctrl_pkg.sv | 28 ++
 rtl/fastram_cycle_ctrl_strobe_sync.sv | 31 +++
 rtl/fastram_cycle_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fastram_cycle_ctrl_pkg.sv
// rtl/fastram_cycle_ctrl_pkg.sv - shared state encodings and parameter limits for the Fast RAM sequencer
// Purpose: state enum for the cycle FSM plus the legal ranges of the timing parameters.
// Ports: none (package).
package fastram_cycle_ctrl_pkg;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_SETUP  = 3'd1;
    localparam logic [2:0] ENC_ACCESS = 3'd2;
    localparam logic [2:0] ENC_ACK    = 3'd3;
    localparam logic [2:0] ENC_HOLD   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_SETUP  = ENC_SETUP,
        ST_ACCESS = ENC_ACCESS,
        ST_ACK    = ENC_ACK,
        ST_HOLD   = ENC_HOLD
    } state_t;

    localparam int WAIT_CYC_MIN = 1;
    localparam int WAIT_CYC_MAX = 15;
    localparam int SYNC_STG_MIN = 2;
    localparam int SYNC_STG_MAX = 3;

    // Wide enough for WAIT_CYC_MAX-1.
    localparam int CNT_W = 4;

endpackage

// File: rtl/fastram_cycle_ctrl_strobe_sync.sv
// rtl/fastram_cycle_ctrl_strobe_sync.sv - multi-flop synchroniser for the three 68000 strobes
// Purpose: brings _AS/_UDS/_LDS into the CLK domain through SYNC_STG flops.
// Ports: CLK, RST (sync, active high), i_d[2:0] raw active-low strobes,
//        o_q[2:0] synchronised active-low strobes (reset to all negated).
module fastram_cycle_ctrl_strobe_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] i_d,
    output logic [2:0] o_q
);

    logic [2:0] r_chain [SYNC_STG];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STG; i++) begin
                r_chain[i] <= 3'b111;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < SYNC_STG; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[SYNC_STG-1];

endmodule

// File: rtl/fastram_cycle_ctrl.sv
// rtl/fastram_cycle_ctrl.sv - Fast RAM SRAM cycle sequencer behind the autoconfig decoder
// Purpose: synchronises the CPU strobes, latches address/direction/lanes at cycle start,
//          sequences SETUP -> ACCESS (WAIT_CYC clocks) -> ACK -> HOLD and returns DTACK.
// Ports: CLK, RST (sync, active high); _AS/_UDS/_LDS async active-low strobes; RW (1 = read);
//        ramce base-address match; A word address;
//        ram_a, _ram_ce/_ram_oe/_ram_we/_ram_ub/_ram_lb SRAM controls; data_oe CPU buffer
//        enable; DTACK (positive logic); busy (not idle). All outputs are registered.
module fastram_cycle_ctrl
    import fastram_cycle_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int WAIT_CYC = 2,
    parameter int SYNC_STG = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              _AS,
    input  logic              _UDS,
    input  logic              _LDS,
    input  logic              RW,
    input  logic              ramce,
    input  logic [ADDR_W-1:0] A,
    output logic [ADDR_W-1:0] ram_a,
    output logic              _ram_ce,
    output logic              _ram_oe,
    output logic              _ram_we,
    output logic              _ram_ub,
    output logic              _ram_lb,
    output logic              data_oe,
    output logic              DTACK,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    logic [2:0]        w_sync_q;
    logic              w_as_s;
    logic              w_uds_s;
    logic              w_lds_s;

    state_t            r_state;
    state_t            w_next;
    logic              w_start;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rw;
    logic              r_ub;
    logic              r_lb;
    logic [ADDR_W-1:0] r_ram_a;

    logic              w_rd;
    logic              w_ub;
    logic              w_lb;
    logic              w_act;

    logic              r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_data_oe, r_dtack, r_busy;
    logic              w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n, w_data_oe, w_dtack, w_busy;

    fastram_cycle_ctrl_strobe_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_sync (
        .CLK (CLK),
        .RST (RST),
        .i_d ({_AS, _UDS, _LDS}),
        .o_q (w_sync_q)
    );

    assign w_as_s  = ~w_sync_q[2];
    assign w_uds_s = ~w_sync_q[1];
    assign w_lds_s = ~w_sync_q[0];

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A strobe without ramce belongs to another device: stay silent.
                if (w_as_s && (w_uds_s || w_lds_s) && ramce) begin
                    w_next  = ST_SETUP;
                    w_start = 1'b1;
                end
            end
            ST_SETUP:  w_next = w_as_s ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: begin
                if (!w_as_s) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK:    w_next = ST_HOLD;
            ST_HOLD:   w_next = w_as_s ? ST_HOLD : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase

        // Outputs are decoded from the state being entered so they land in the
        // same register update as the state change. On cycle start the fresh
        // direction/lane values are used since the latches update on that edge.
        w_rd  = w_start ? RW      : r_rw;
        w_ub  = w_start ? w_uds_s : r_ub;
        w_lb  = w_start ? w_lds_s : r_lb;
        w_act = (w_next != ST_IDLE);

        w_ce_n    = ~w_act;
        w_ub_n    = ~(w_act & w_ub);
        w_lb_n    = ~(w_act & w_lb);
        w_oe_n    = ~(w_act & w_rd);
        w_data_oe = w_act & w_rd;
        // WE only in ACCESS: released in ACK to give data hold before DTACK.
        w_we_n    = ~((w_next == ST_ACCESS) & ~w_rd);
        w_dtack   = (w_next == ST_ACK) | (w_next == ST_HOLD);
        w_busy    = w_act;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rw      <= 1'b1;
            r_ub      <= 1'b0;
            r_lb      <= 1'b0;
            r_ram_a   <= '0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_ub_n    <= 1'b1;
            r_lb_n    <= 1'b1;
            r_data_oe <= 1'b0;
            r_dtack   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_ram_a <= A;
                r_rw    <= RW;
                r_ub    <= w_uds_s;
                r_lb    <= w_lds_s;
            end
            if (r_state == ST_SETUP) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_ce_n    <= w_ce_n;
            r_oe_n    <= w_oe_n;
            r_we_n    <= w_we_n;
            r_ub_n    <= w_ub_n;
            r_lb_n    <= w_lb_n;
            r_data_oe <= w_data_oe;
            r_dtack   <= w_dtack;
            r_busy    <= w_busy;
        end
    end

    assign ram_a   = r_ram_a;
    assign _ram_ce = r_ce_n;
    assign _ram_oe = r_oe_n;
    assign _ram_we = r_we_n;
    assign _ram_ub = r_ub_n;
    assign _ram_lb = r_lb_n;
    assign data_oe = r_data_oe;
    assign DTACK   = r_dtack;
    assign busy    = r_busy;

endmodule
